// File: rtl/draw_scheduler.sv
// Frame sequencer: optional full-screen clear (fillscreen engine), then one Reuleaux pass, muxed and clipped onto one VGA plot port.
// Build option: define DRAW_SCHED_CLEAR_EN to enable the clear pass; otherwise a frame goes straight to the shape pass.
module draw_scheduler #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] diameter,
    output logic       done,
    output logic       fill_start,
    input  logic       fill_done,
    input  logic [7:0] fill_vga_x,
    input  logic [6:0] fill_vga_y,
    input  logic [2:0] fill_vga_colour,
    input  logic       fill_vga_plot,
    output logic       shape_start,
    input  logic       shape_done,
    output logic [2:0] shape_colour,
    output logic [7:0] shape_centre_x,
    output logic [6:0] shape_centre_y,
    output logic [7:0] shape_diameter,
    input  logic [7:0] shape_vga_x,
    input  logic [6:0] shape_vga_y,
    input  logic [2:0] shape_vga_colour,
    input  logic       shape_vga_plot,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] GAP   = 3'd2;
    localparam logic [2:0] DRAW  = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    localparam logic [8:0] XLIM = 9'(SCREEN_W);
    localparam logic [7:0] YLIM = 8'(SCREEN_H);

    logic [2:0] state_q, state_d;
    logic       fill_start_q, shape_start_q, done_q;
    logic [2:0] shape_colour_q;
    logic [7:0] shape_centre_x_q;
    logic [6:0] shape_centre_y_q;
    logic [7:0] shape_diameter_q;
    logic [7:0] vga_x_q;
    logic [6:0] vga_y_q;
    logic [2:0] vga_colour_q;
    logic       vga_plot_q;

    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_colour;
    logic       sel_plot;
    logic       in_view;

    // Dropping start anywhere mid-frame aborts back to IDLE without a done pulse.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
`ifdef DRAW_SCHED_CLEAR_EN
                    state_d = CLEAR;
`else
                    state_d = DRAW;
`endif
                end
            end
            CLEAR: begin
`ifdef DRAW_SCHED_CLEAR_EN
                if (!start)         state_d = IDLE;
                else if (fill_done) state_d = GAP;
`else
                state_d = IDLE;
`endif
            end
            GAP: begin
`ifdef DRAW_SCHED_CLEAR_EN
                state_d = start ? DRAW : IDLE;
`else
                state_d = IDLE;
`endif
            end
            DRAW: begin
                if (!start)          state_d = IDLE;
                else if (shape_done) state_d = DONE;
            end
            DONE: begin
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Selection follows the current state, so the last sample of an exiting state still drains through.
    always_comb begin
        sel_x      = 8'd0;
        sel_y      = 7'd0;
        sel_colour = 3'd0;
        sel_plot   = 1'b0;
`ifdef DRAW_SCHED_CLEAR_EN
        if (state_q == CLEAR) begin
            sel_x      = fill_vga_x;
            sel_y      = fill_vga_y;
            sel_colour = fill_vga_colour;
            sel_plot   = fill_vga_plot;
        end
`endif
        if (state_q == DRAW) begin
            sel_x      = shape_vga_x;
            sel_y      = shape_vga_y;
            sel_colour = shape_vga_colour;
            sel_plot   = shape_vga_plot;
        end
    end

    assign in_view = ({1'b0, sel_x} < XLIM) && ({1'b0, sel_y} < YLIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            fill_start_q     <= 1'b0;
            shape_start_q    <= 1'b0;
            done_q           <= 1'b0;
            shape_colour_q   <= 3'd0;
            shape_centre_x_q <= 8'd0;
            shape_centre_y_q <= 7'd0;
            shape_diameter_q <= 8'd0;
            vga_x_q          <= 8'd0;
            vga_y_q          <= 7'd0;
            vga_colour_q     <= 3'd0;
            vga_plot_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fill_start_q  <= (state_d == CLEAR);
            shape_start_q <= (state_d == DRAW);
            done_q        <= (state_d == DONE);
            if (state_q == IDLE && start) begin
                shape_colour_q   <= colour;
                shape_centre_x_q <= centre_x;
                shape_centre_y_q <= centre_y;
                shape_diameter_q <= diameter;
            end
            vga_x_q      <= sel_x;
            vga_y_q      <= sel_y;
            vga_colour_q <= sel_colour;
            vga_plot_q   <= sel_plot && in_view;
        end
    end

`ifdef DRAW_SCHED_CLEAR_EN
    assign fill_start = fill_start_q;
`else
    logic fill_unused;
    assign fill_unused = ^{fill_done, fill_vga_x, fill_vga_y, fill_vga_colour,
                           fill_vga_plot, fill_start_q};
    assign fill_start  = 1'b0;
`endif

    assign shape_start    = shape_start_q;
    assign done           = done_q;
    assign shape_colour   = shape_colour_q;
    assign shape_centre_x = shape_centre_x_q;
    assign shape_centre_y = shape_centre_y_q;
    assign shape_diameter = shape_diameter_q;
    assign vga_x          = vga_x_q;
    assign vga_y          = vga_y_q;
    assign vga_colour     = vga_colour_q;
    assign vga_plot       = vga_plot_q;

endmodule

// File: tb/tb_draw_scheduler.sv
// Directed bench for draw_scheduler; expectations follow DRAW_SCHED_CLEAR_EN the same way the design does.
module tb_draw_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [2:0] colour = 3'd0;
    logic [7:0] centre_x = 8'd0;
    logic [6:0] centre_y = 7'd0;
    logic [7:0] diameter = 8'd0;
    logic       done;
    logic       fill_start;
    logic       fill_done = 1'b0;
    logic [7:0] fill_vga_x = 8'd0;
    logic [6:0] fill_vga_y = 7'd0;
    logic [2:0] fill_vga_colour = 3'd0;
    logic       fill_vga_plot = 1'b0;
    logic       shape_start;
    logic       shape_done = 1'b0;
    logic [2:0] shape_colour;
    logic [7:0] shape_centre_x;
    logic [6:0] shape_centre_y;
    logic [7:0] shape_diameter;
    logic [7:0] shape_vga_x = 8'd0;
    logic [6:0] shape_vga_y = 7'd0;
    logic [2:0] shape_vga_colour = 3'd0;
    logic       shape_vga_plot = 1'b0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    int total = 0;
    int bad = 0;

    logic [47:0] all_outs;
    assign all_outs = {fill_start, shape_start, done, vga_plot, vga_x, vga_y, vga_colour,
                       shape_colour, shape_centre_x, shape_centre_y, shape_diameter};

    logic [25:0] params;
    assign params = {shape_colour, shape_centre_x, shape_centre_y, shape_diameter};
    localparam logic [25:0] FRAME_PARAMS = {3'b010, 8'd80, 7'd60, 8'd80};

    draw_scheduler #(.SCREEN_W(160), .SCREEN_H(120)) dut (
        .clk(clk), .rst(rst), .start(start),
        .colour(colour), .centre_x(centre_x), .centre_y(centre_y), .diameter(diameter),
        .done(done),
        .fill_start(fill_start), .fill_done(fill_done),
        .fill_vga_x(fill_vga_x), .fill_vga_y(fill_vga_y),
        .fill_vga_colour(fill_vga_colour), .fill_vga_plot(fill_vga_plot),
        .shape_start(shape_start), .shape_done(shape_done),
        .shape_colour(shape_colour), .shape_centre_x(shape_centre_x),
        .shape_centre_y(shape_centre_y), .shape_diameter(shape_diameter),
        .shape_vga_x(shape_vga_x), .shape_vga_y(shape_vga_y),
        .shape_vga_colour(shape_vga_colour), .shape_vga_plot(shape_vga_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        colour = 3'b101; centre_x = 8'd33; centre_y = 7'd44; diameter = 8'd55;
        shape_vga_x = 8'd5; shape_vga_y = 7'd5; shape_vga_plot = 1'b1;
        tick(); tick();
        total++; if (all_outs !== 48'd0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", all_outs); end
        rst = 1'b0;
        tick();
`ifdef DRAW_SCHED_CLEAR_EN
        total++; if ({fill_start, shape_start} !== 2'b10) begin bad++; $display("FAIL reset_release_starts got=%b exp=10", {fill_start, shape_start}); end
`else
        total++; if ({fill_start, shape_start} !== 2'b01) begin bad++; $display("FAIL reset_release_starts got=%b exp=01", {fill_start, shape_start}); end
`endif
        total++; if (shape_colour !== 3'b101) begin bad++; $display("FAIL reset_release_latch got=%b exp=101", shape_colour); end
        start = 1'b0; shape_vga_plot = 1'b0;
        tick(); tick();
        total++; if ({fill_start, shape_start, done, vga_plot} !== 4'b0000) begin bad++; $display("FAIL reset_abort_idle got=%b exp=0000", {fill_start, shape_start, done, vga_plot}); end
    endtask

    task automatic test_frame_start();
        int pix_err;
        colour = 3'b010; centre_x = 8'd80; centre_y = 7'd60; diameter = 8'd80;
`ifdef DRAW_SCHED_CLEAR_EN
        start = 1'b1;
        tick();
        total++; if ({fill_start, shape_start} !== 2'b10) begin bad++; $display("FAIL frame_clear_entry got=%b exp=10", {fill_start, shape_start}); end
        pix_err = 0;
        for (int i = 0; i < 19200; i++) begin
            fill_vga_x = 8'(i % 160); fill_vga_y = 7'(i / 160);
            fill_vga_colour = 3'(i); fill_vga_plot = 1'b1;
            tick();
            if ({vga_plot, vga_x, vga_y, vga_colour} !== {1'b1, 8'(i % 160), 7'(i / 160), 3'(i)}) pix_err++;
        end
        total++; if (pix_err !== 0) begin bad++; $display("FAIL frame_fill_stream bad_pixels got=%0d exp=0", pix_err); end
        total++; if (fill_start !== 1'b1) begin bad++; $display("FAIL frame_fill_held got=%b exp=1", fill_start); end
        fill_vga_plot = 1'b0; fill_done = 1'b1;
        tick();
        total++; if ({fill_start, shape_start, vga_plot} !== 3'b000) begin bad++; $display("FAIL frame_gap got=%b exp=000", {fill_start, shape_start, vga_plot}); end
        fill_done = 1'b0;
        tick();
        total++; if ({fill_start, shape_start} !== 2'b01) begin bad++; $display("FAIL frame_draw_entry got=%b exp=01", {fill_start, shape_start}); end
        total++; if (params !== FRAME_PARAMS) begin bad++; $display("FAIL frame_params got=%h exp=%h", params, FRAME_PARAMS); end
`else
        start = 1'b1;
        fill_vga_x = 8'd2; fill_vga_y = 7'd2; fill_vga_plot = 1'b1; fill_done = 1'b1;
        tick();
        total++; if ({fill_start, shape_start} !== 2'b01) begin bad++; $display("FAIL direct_draw_entry got=%b exp=01", {fill_start, shape_start}); end
        total++; if (params !== FRAME_PARAMS) begin bad++; $display("FAIL direct_params got=%h exp=%h", params, FRAME_PARAMS); end
        fill_done = 1'b0;
        tick();
        total++; if ({fill_start, vga_plot} !== 2'b00) begin bad++; $display("FAIL direct_fill_ignored got=%b exp=00", {fill_start, vga_plot}); end
        fill_vga_plot = 1'b0;
`endif
    endtask

    task automatic test_clip();
        logic [7:0] xs [5] = '{8'd165, 8'd159, 8'd160, 8'd0, 8'd159};
        logic [6:0] ys [5] = '{7'd10, 7'd119, 7'd0, 7'd120, 7'd0};
        logic       ps [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        shape_vga_colour = 3'b011; shape_vga_plot = 1'b1;
        for (int i = 0; i < 5; i++) begin
            shape_vga_x = xs[i]; shape_vga_y = ys[i];
            tick();
            total++;
            if ({vga_plot, vga_x, vga_y, vga_colour} !== {ps[i], xs[i], ys[i], 3'b011}) begin
                bad++;
                $display("FAIL clip_%0d got plot=%b x=%0d y=%0d c=%b exp plot=%b x=%0d y=%0d c=011",
                         i, vga_plot, vga_x, vga_y, vga_colour, ps[i], xs[i], ys[i]);
            end
        end
        shape_vga_plot = 1'b0;
    endtask

    task automatic test_latching();
        colour = 3'b111; centre_x = 8'd20; centre_y = 7'd5; diameter = 8'd9;
        tick(); tick();
        total++; if (params !== FRAME_PARAMS) begin bad++; $display("FAIL latch_hold got=%h exp=%h", params, FRAME_PARAMS); end
        total++; if (shape_start !== 1'b1) begin bad++; $display("FAIL latch_still_drawing got=%b exp=1", shape_start); end
    endtask

    task automatic test_done();
        shape_vga_x = 8'd5; shape_vga_y = 7'd5; shape_vga_colour = 3'b001;
        shape_vga_plot = 1'b1; shape_done = 1'b1;
        tick();
        total++; if ({shape_start, done} !== 2'b01) begin bad++; $display("FAIL done_rise got=%b exp=01", {shape_start, done}); end
        total++; if ({vga_plot, vga_x} !== {1'b1, 8'd5}) begin bad++; $display("FAIL done_drain got plot=%b x=%0d exp plot=1 x=5", vga_plot, vga_x); end
        shape_done = 1'b0;
        tick();
        total++; if ({done, vga_plot} !== 2'b10) begin bad++; $display("FAIL done_hold got=%b exp=10", {done, vga_plot}); end
        start = 1'b0; shape_vga_plot = 1'b0;
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL done_fall got=%b exp=0", done); end
    endtask

    task automatic test_abort();
        start = 1'b1;
`ifdef DRAW_SCHED_CLEAR_EN
        fill_vga_x = 8'd1; fill_vga_y = 7'd1; fill_vga_plot = 1'b1;
        tick();
        total++; if (fill_start !== 1'b1) begin bad++; $display("FAIL abort_clear_entry got=%b exp=1", fill_start); end
        start = 1'b0;
        tick();
        total++; if ({fill_start, vga_plot} !== 2'b01) begin bad++; $display("FAIL abort_drop got=%b exp=01", {fill_start, vga_plot}); end
`else
        tick();
        total++; if (shape_start !== 1'b1) begin bad++; $display("FAIL abort_draw_entry got=%b exp=1", shape_start); end
        start = 1'b0;
        tick();
        total++; if (shape_start !== 1'b0) begin bad++; $display("FAIL abort_drop got=%b exp=0", shape_start); end
`endif
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if ({done, vga_plot, fill_start, shape_start} !== 4'b0000) begin bad++; $display("FAIL abort_idle_%0d got=%b exp=0000", i, {done, vga_plot, fill_start, shape_start}); end
        end
        fill_vga_plot = 1'b0;
        start = 1'b1;
        tick();
`ifdef DRAW_SCHED_CLEAR_EN
        total++; if ({fill_start, shape_start} !== 2'b10) begin bad++; $display("FAIL abort_restart got=%b exp=10", {fill_start, shape_start}); end
`else
        total++; if ({fill_start, shape_start} !== 2'b01) begin bad++; $display("FAIL abort_restart got=%b exp=01", {fill_start, shape_start}); end
`endif
    endtask

    task automatic test_reset_mid_draw();
`ifdef DRAW_SCHED_CLEAR_EN
        fill_done = 1'b1;
        tick();
        fill_done = 1'b0;
        tick();
`endif
        total++; if (shape_start !== 1'b1) begin bad++; $display("FAIL middraw_entry got=%b exp=1", shape_start); end
        shape_vga_x = 8'd3; shape_vga_y = 7'd3; shape_vga_plot = 1'b1;
        rst = 1'b1;
        tick();
        total++; if (all_outs !== 48'd0) begin bad++; $display("FAIL middraw_reset got=%h exp=0", all_outs); end
        rst = 1'b0; start = 1'b0; shape_vga_plot = 1'b0;
        tick();
        total++; if ({fill_start, shape_start, done} !== 3'b000) begin bad++; $display("FAIL middraw_after got=%b exp=000", {fill_start, shape_start, done}); end
    endtask

    initial begin
        test_reset();
        test_frame_start();
        test_clip();
        test_latching();
        test_done();
        test_abort();
        test_reset_mid_draw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_scheduler.md
# draw_scheduler

Frame-level controller that sequences the two drawing engines behind the VGA adapter: a full-screen clear pass (fillscreen engine), then one shape pass (Reuleaux engine). It owns the single VGA plot port, muxes whichever engine is active onto it, and clips off-screen pixels. The inputs are latched per frame, and the block presents one start/done handshake to the top level.

## Interface
- `SCREEN_W`, default 160: visible width; plots with x ≥ SCREEN_W are dropped.
- `SCREEN_H`, default 120: visible height; plots with y ≥ SCREEN_H are dropped.

- `clk` in 1: system clock (CLOCK_50 domain).
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: frame request, level; held high until `done` is seen.
- `colour` in 3, `centre_x` in 8, `centre_y` in 7, `diameter` in 8: shape parameters; latched when a frame is accepted.
- `done` out 1: frame complete; held high while `start` stays high.
- `fill_start` out 1 / `fill_done` in 1: fillscreen engine handshake.
- `fill_vga_x` in 8, `fill_vga_y` in 7, `fill_vga_colour` in 3, `fill_vga_plot` in 1: fillscreen pixel stream.
- `shape_start` out 1 / `shape_done` in 1: Reuleaux engine handshake.
- `shape_colour` out 3, `shape_centre_x` out 8, `shape_centre_y` out 7, `shape_diameter` out 8: latched parameters driven to the Reuleaux engine.
- `shape_vga_x` in 8, `shape_vga_y` in 7, `shape_vga_colour` in 3, `shape_vga_plot` in 1: Reuleaux pixel stream.
- `vga_x` out 8, `vga_y` out 7, `vga_colour` out 3, `vga_plot` out 1: the merged stream to the VGA adapter.

## Operation
- The FSM has five states: IDLE, CLEAR, GAP, DRAW, DONE.
- **IDLE:** on `start`=1, latch `colour`, `centre_x`, `centre_y` and `diameter` into the `shape_*` registers, then go to CLEAR.
- **CLEAR:** `fill_start`=1. On `fill_done`=1, go to GAP.
- **GAP:** one cycle with both engine starts at 0, so the fillscreen engine returns to idle. Then go to DRAW.
- **DRAW:** `shape_start`=1. On `shape_done`=1, go to DONE.
- **DONE:** `done`=1 and both engine starts at 0. On `start`=0, go to IDLE.
- **Abort:** `start`=0 while in CLEAR, GAP or DRAW sends the FSM to IDLE on the next edge. Engine starts drop, and `done` is never asserted for that frame.
- **Mux:** in CLEAR, the fill stream is selected. In DRAW, the shape stream is selected. In all other states, `vga_plot` is 0.
- **Clip:** the selected plot is forwarded only if x < SCREEN_W and y < SCREEN_H. Otherwise `vga_plot`=0 for that cycle; x, y and colour still pass through.
- **Latched parameters:** `shape_*` hold their latched values until the next accepted frame. Input changes mid-frame are ignored.
- **Reset value of all outputs:** 0. Reset also clears the latched parameters.

## Timing
- All outputs are registered.
- `vga_*` lag the selected engine inputs by exactly 1 cycle.
- `start` sampled high in IDLE at edge k gives `fill_start`=1 from edge k+1.
- `fill_done` sampled high at edge m gives `fill_start`=0 from m+1 (GAP) and `shape_start`=1 from m+2.
- `shape_done` sampled high at edge n gives `shape_start`=0 and `done`=1 from n+1.
- `start` sampled low in DONE gives `done`=0 from the next edge.
- A new frame is accepted no earlier than the cycle after IDLE is re-entered.
- Engine outputs sampled in the cycle a state is exited are still forwarded; this is the 1-cycle pipeline drain.
- `rst` has priority over every other input. Asserted mid-frame, it gives IDLE with all outputs at 0 on the next edge.

## Configuration
- Macro `DRAW_SCHED_CLEAR_EN`.
- **Defined:** the full IDLE→CLEAR→GAP→DRAW→DONE sequence applies.
- **Undefined:**
  - IDLE with `start`=1 goes directly to DRAW; CLEAR and GAP are unreachable.
  - `fill_start` is constant 0 and all `fill_*` inputs are ignored.
  - Latency from `start` to `shape_start` becomes 1 cycle.

## Test plan
- **Reset:** `rst`=1 for 2 cycles with `start`=1 → all outputs 0 and the FSM is in IDLE. Release `rst` → `fill_start`=1 one cycle later.
- **Full frame:**
  - Stimulus: `colour`=3'b010, centre (80,60), `diameter`=80. A fill stub plots 19200 pixels, then raises `fill_done`.
  - Response: `fill_start` falls, exactly one GAP cycle follows, then `shape_start`=1 with `shape_colour`=010, `shape_centre_x`=80, `shape_centre_y`=60, `shape_diameter`=80.
  - Stub `shape_done` → `done`=1. `start`=0 → `done`=0 next cycle.
- **Clip:** in DRAW, shape stub drives (165,10) → `vga_plot`=0. It drives (159,119) → `vga_plot`=1 one cycle later with `vga_x`=159, `vga_y`=119.
- **Latching:** change `colour` to 3'b111 and `centre_x` to 20 during DRAW → `shape_colour` stays 010 and `shape_centre_x` stays 80.
- **Abort and reset mid-frame:**
  - `start`=0 mid-CLEAR → `fill_start`=0 and `vga_plot`=0 on the following cycles, and `done` never rises. A new `start` begins in CLEAR again.
  - `rst`=1 mid-DRAW → all outputs 0 next cycle.
- **Macro undefined:** `start`=1 → `shape_start`=1 one cycle later. `fill_start` stays 0 throughout, even with a fill stub toggling `fill_vga_plot`.
